// File: rtl/mult_div_pkg.sv
// Shared types and sizing for the multiply/divide unit.
package mult_div_pkg;

   localparam int unsigned MDU_WIDTH = 32;
   localparam int unsigned MDU_CNT_W = $clog2(MDU_WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE,
      MULT,
      DIV,
      DONE
   } mdu_state_t;

   // Counter must hold the value WIDTH itself, hence the extra bit.
   function automatic int unsigned mdu_cnt_width(input int unsigned w);
      return $clog2(w) + 1;
   endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step on unsigned magnitudes.
module div_step import mult_div_pkg::*; #(
   parameter int unsigned WIDTH = MDU_WIDTH
) (
   input  logic [WIDTH-1:0] rem_in,
   input  logic [WIDTH-1:0] divisor,
   input  logic             dividend_bit,
   output logic [WIDTH-1:0] rem_out,
   output logic             q_bit
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   always_comb begin
      shifted = {rem_in, dividend_bit};
      diff    = shifted - {1'b0, divisor};
      q_bit   = (shifted >= {1'b0, divisor});
      // A failed trial leaves shifted < divisor, so it always fits WIDTH bits.
      rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
   end

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed MULT (radix-2 Booth) / DIV (restoring) unit owning HI/LO.
module mult_div_unit import mult_div_pkg::*; #(
   parameter int unsigned WIDTH = MDU_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             mult_start,
   input  logic             div_start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             div_zero
);

   localparam int unsigned CW = mdu_cnt_width(WIDTH);
   localparam int unsigned AW = 2 * WIDTH + 1;

   mdu_state_t state, state_nx;

   logic [CW-1:0]    cnt;
   logic [AW-1:0]    acc, acc_nx;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] dvd, dvs, rem, rem_nx;
   logic [WIDTH-1:0] a_mag, b_mag, quo_fix, rem_fix;
   logic [WIDTH:0]   booth_up, booth_m, booth_sum;
   logic             q_bit, q_neg, r_neg, dz_q;
   logic             last, dvs_zero;
   logic             acc_mult, acc_div, fin_mult, fin_div, dz_hit, step_en;

   assign last     = (cnt == CW'(WIDTH));
   assign dvs_zero = (dvs == '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      done     = 1'b0;
      div_zero = 1'b0;
      acc_mult = 1'b0;
      acc_div  = 1'b0;
      fin_mult = 1'b0;
      fin_div  = 1'b0;
      dz_hit   = 1'b0;
      step_en  = 1'b0;
      case (state)
         IDLE: begin
            if (mult_start) begin
               acc_mult = 1'b1;
               state_nx = MULT;
            end else if (div_start) begin
               acc_div  = 1'b1;
               state_nx = DIV;
            end
         end
         MULT: begin
            busy = 1'b1;
            if (last) begin
               fin_mult = 1'b1;
               state_nx = DONE;
            end else begin
               step_en = 1'b1;
            end
         end
         DIV: begin
            busy = 1'b1;
            if (dvs_zero) begin
               dz_hit   = 1'b1;
               state_nx = DONE;
            end else if (last) begin
               fin_div  = 1'b1;
               state_nx = DONE;
            end else begin
               step_en = 1'b1;
            end
         end
         DONE: begin
            busy     = 1'b1;
            done     = 1'b1;
            div_zero = dz_q;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Booth add is done one bit wider so a most-negative multiplicand cannot overflow.
   always_comb begin
      booth_up = {acc[AW-1], acc[AW-1:WIDTH+1]};
      booth_m  = {mcand[WIDTH-1], mcand};
      case (acc[1:0])
         2'b01:   booth_sum = booth_up + booth_m;
         2'b10:   booth_sum = booth_up - booth_m;
         default: booth_sum = booth_up;
      endcase
      acc_nx = {booth_sum, acc[WIDTH:1]};
   end

   always_comb begin
      a_mag   = a[WIDTH-1] ? -a : a;
      b_mag   = b[WIDTH-1] ? -b : b;
      quo_fix = q_neg ? -dvd : dvd;
      rem_fix = r_neg ? -rem : rem;
   end

   div_step #(.WIDTH(WIDTH)) u_div_step (
      .rem_in       (rem),
      .divisor      (dvs),
      .dividend_bit (dvd[WIDTH-1]),
      .rem_out      (rem_nx),
      .q_bit        (q_bit)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hi    <= '0;
         lo    <= '0;
         acc   <= '0;
         mcand <= '0;
         dvd   <= '0;
         dvs   <= '0;
         rem   <= '0;
         cnt   <= '0;
         q_neg <= 1'b0;
         r_neg <= 1'b0;
         dz_q  <= 1'b0;
      end else begin
         if (acc_mult) begin
            mcand <= a;
            acc   <= {{WIDTH{1'b0}}, b, 1'b0};
            cnt   <= '0;
         end
         if (acc_div) begin
            dvd   <= a_mag;
            dvs   <= b_mag;
            rem   <= '0;
            q_neg <= a[WIDTH-1] ^ b[WIDTH-1];
            r_neg <= a[WIDTH-1];
            cnt   <= '0;
         end
         if (step_en) begin
            cnt <= cnt + CW'(1);
            if (state == MULT) begin
               acc <= acc_nx;
            end else begin
               rem <= rem_nx;
               dvd <= {dvd[WIDTH-2:0], q_bit};
            end
         end
         if (fin_mult) begin
            hi   <= acc[AW-1:WIDTH+1];
            lo   <= acc[WIDTH:1];
            dz_q <= 1'b0;
         end
         if (fin_div) begin
            hi   <= rem_fix;
            lo   <= quo_fix;
            dz_q <= 1'b0;
         end
         if (dz_hit) dz_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit with hand-computed HI/LO results.
module tb_mult_div_unit;

   logic        clk;
   logic        reset;
   logic        mult_start;
   logic        div_start;
   logic [31:0] a;
   logic [31:0] b;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        done;
   logic        div_zero;

   int checks   = 0;
   int failures = 0;
   int done_cnt = 0;
   logic [31:0] prev_hi = '0;
   logic [31:0] prev_lo = '0;

   mult_div_unit #(.WIDTH(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .mult_start (mult_start),
      .div_start  (div_start),
      .a          (a),
      .b          (b),
      .hi         (hi),
      .lo         (lo),
      .busy       (busy),
      .done       (done),
      .div_zero   (div_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (done === 1'b1) done_cnt++;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // mode: 0 = MULT, 1 = DIV, 2 = both starts together.
   task automatic do_op(input string tag, input int mode,
                        input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] ehi, input logic [31:0] elo,
                        input logic edz, input int elat, input int poke, input bit b2b);
      int lat;
      int dc0;
      @(negedge clk);
      a          = av;
      b          = bv;
      mult_start = (mode != 1);
      div_start  = (mode != 0);
      dc0        = done_cnt;
      @(posedge clk); #1;
      mult_start = 1'b0;
      div_start  = 1'b0;
      check_eq({tag, "_busy"}, 32'(busy), 32'd1);
      lat = 0;
      while (done !== 1'b1 && lat < 200) begin
         @(posedge clk); #1;
         lat++;
         div_start = (lat == poke);
         if (lat == 5) begin
            check_eq({tag, "_hold_hi"}, hi, prev_hi);
            check_eq({tag, "_hold_lo"}, lo, prev_lo);
         end
      end
      div_start = 1'b0;
      check_eq({tag, "_lat"}, 32'(lat), 32'(elat));
      check_eq({tag, "_done"}, 32'(done), 32'd1);
      check_eq({tag, "_hi"}, hi, ehi);
      check_eq({tag, "_lo"}, lo, elo);
      check_eq({tag, "_dz"}, 32'(div_zero), 32'(edz));
      if (b2b) mult_start = 1'b1;
      @(posedge clk); #1;
      mult_start = 1'b0;
      check_eq({tag, "_done_drop"}, 32'(done), 32'd0);
      check_eq({tag, "_idle"}, 32'(busy), 32'd0);
      check_eq({tag, "_ndone"}, 32'(done_cnt - dc0), 32'd1);
      if (!edz) begin
         prev_hi = ehi;
         prev_lo = elo;
      end
   endtask

   initial begin
      int dc0;
      reset      = 1'b0;
      mult_start = 1'b0;
      div_start  = 1'b0;
      a          = '0;
      b          = '0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_hi",   hi,              32'h0);
      check_eq("rst_lo",   lo,              32'h0);
      check_eq("rst_busy", 32'(busy),       32'd0);
      check_eq("rst_done", 32'(done),       32'd0);
      check_eq("rst_dz",   32'(div_zero),   32'd0);
      @(negedge clk) reset = 1'b1;

      do_op("mul_4x3",    0, 32'd4,        32'd3,        32'h0000_0000, 32'h0000_000C, 1'b0, 33, -1, 1'b0);
      do_op("mul_m6x3",   0, 32'hFFFF_FFFA, 32'd3,       32'hFFFF_FFFF, 32'hFFFF_FFEE, 1'b0, 33, -1, 1'b0);
      do_op("mul_maxsq",  0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 1'b0, 33, -1, 1'b0);
      do_op("mul_minsq",  0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 33, -1, 1'b0);
      do_op("div_m7_2",   1, 32'hFFFF_FFF9, 32'd2,       32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33, -1, 1'b0);
      do_op("div_min_m1", 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 33, -1, 1'b0);
      do_op("div_100_m7", 1, 32'd100,      32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2, 1'b0, 33, -1, 1'b0);
      do_op("div_21_7",   1, 32'd21,       32'd7,        32'h0000_0000, 32'h0000_0003, 1'b0, 33, -1, 1'b0);
      do_op("div_zero",   1, 32'd5,        32'd0,        32'h0000_0000, 32'h0000_0003, 1'b1,  1, -1, 1'b1);
      do_op("mul_poke",   0, 32'd5,        32'd7,        32'h0000_0000, 32'h0000_0023, 1'b0, 33, 10, 1'b0);
      do_op("both_start", 2, 32'd9,        32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFEE, 1'b0, 33, -1, 1'b0);

      // Asynchronous reset mid-way through a multiply.
      @(negedge clk);
      a          = 32'd100;
      b          = 32'd200;
      mult_start = 1'b1;
      dc0        = done_cnt;
      @(posedge clk); #1;
      mult_start = 1'b0;
      repeat (15) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      check_eq("arst_hi",   hi,            32'h0);
      check_eq("arst_lo",   lo,            32'h0);
      check_eq("arst_busy", 32'(busy),     32'd0);
      check_eq("arst_done", 32'(done),     32'd0);
      check_eq("arst_dz",   32'(div_zero), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) reset = 1'b1;
      prev_hi = '0;
      prev_lo = '0;
      repeat (40) @(posedge clk);
      #1;
      check_eq("arst_no_done", 32'(done_cnt - dc0), 32'd0);
      check_eq("arst_idle",    32'(busy),           32'd0);

      do_op("div_21_7_post", 1, 32'd21, 32'd7, 32'h0000_0000, 32'h0000_0003, 1'b0, 33, -1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multicycle signed multiply/divide unit answering the control unit's MULT/DIV requests and holding the HI/LO architectural registers read by MFHI/MFLO. The control unit issues a one-cycle start, waits for `done` and samples `div_zero` for its exception path. The unit sits beside the ALU in the datapath and takes rs/rt operands from the A/B registers.

## Interface
- `WIDTH`, 32: operand width; the iteration count equals `WIDTH`.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `mult_start`  in  1  one-cycle request: signed multiply `a*b`.
- `div_start`  in  1  one-cycle request: signed divide `a/b`.
- `a`  in  WIDTH  rs operand (multiplicand / dividend), sampled with the start pulse.
- `b`  in  WIDTH  rt operand (multiplier / divisor), sampled with the start pulse.
- `hi`  out  WIDTH  HI register: upper product half, or remainder.
- `lo`  out  WIDTH  LO register: lower product half, or quotient.
- `busy`  out  1  high from the cycle after start acceptance until `done` drops.
- `done`  out  1  one-cycle completion pulse.
- `div_zero`  out  1  high together with `done` when a DIV had `b == 0`; low otherwise.

## Operation
- States: IDLE, MULT, DIV, DONE.
- IDLE: starts are accepted only in this state.
  - `mult_start` → MULT; `div_start` → DIV.
  - Both starts high in the same cycle: MULT wins and the DIV request is dropped.
  - On acceptance, `a`/`b` are latched and the iteration counter is cleared.
- Starts in any other state are ignored without side effects.
- MULT: radix-2 Booth, one step per cycle, `WIDTH` steps, on a 2·WIDTH+1-bit accumulator.
  - Result is the full signed 2·WIDTH product: hi = [63:32], lo = [31:0].
- DIV: restoring division on operand magnitudes, one quotient bit per cycle, `WIDTH` steps.
  - Sign fix-up is applied on the exit edge.
  - Quotient truncates toward zero; remainder takes the dividend's sign.
  - -2^31 / -1 gives lo = 0x80000000, hi = 0. No overflow flag.
- Divide by zero: DIV with latched `b == 0` skips iteration and goes to DONE on the next edge.
  - `hi`/`lo` keep their previous values; `div_zero` = 1 during DONE.
- DONE: `done` = 1 for one cycle, then the unit returns to IDLE.
  - `hi`/`lo` are written only on the edge entering DONE from MULT/DIV, and hold otherwise.
- `hi`/`lo` are not cleared by starting a new operation; MFHI/MFLO during `busy` read the previous result.

## Timing
- Reset (asynchronous, any state, including mid-operation):
  - state = IDLE, `hi` = `lo` = 0, `busy` = `done` = `div_zero` = 0.
  - The counter and the operation in flight are discarded.
- Start sampled at edge E0 (normal case):
  - `busy` rises after E0.
  - Iterations run on edges E1..E32.
  - E33 enters DONE and writes `hi`/`lo`.
  - `done` is high in the cycle after E33, so results are valid while `done` = 1.
  - E34 returns to IDLE; `busy` falls with `done`.
- Divide by zero: start at E0, DONE entered at E1, `done` + `div_zero` high for the cycle after E1.
- Back-to-back: a start asserted during the DONE cycle is ignored. The earliest accepted start is the cycle after DONE.
- Latency to `done` = WIDTH + 1 cycles, or 1 cycle for divide-by-zero.

## Structure
- Package `mult_div_pkg` holds:
  - the state enum (IDLE, MULT, DIV, DONE);
  - the default `WIDTH`;
  - the counter width, $clog2(WIDTH)+1.
- Sub-module `div_step`: purely combinational restoring-division step. Inputs are partial remainder, divisor and next dividend bit; outputs are the new remainder and the quotient bit.
- Booth step and sign fix-up stay inline in `mult_div_unit`.

## Test plan
- MULT a=4, b=3 → `done` exactly 33 cycles after the start edge; hi = 0x00000000, lo = 0x0000000C; `div_zero` = 0.
- MULT a=-6 (0xFFFFFFFA), b=3 → hi = 0xFFFFFFFF, lo = 0xFFFFFFEE.
- DIV 21/7 → lo = 3, hi = 0. DIV -7/2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. DIV 0x80000000 / -1 → lo = 0x80000000, hi = 0.
- DIV b=0 after the 21/7 result:
  - `done` + `div_zero` one cycle after the start edge;
  - hi/lo remain 0/3;
  - the next MULT shows `div_zero` = 0.
- `div_start` pulsed at cycle 10 of an active MULT, and simultaneous `mult_start` + `div_start` in IDLE → only the MULT result appears, with a single `done`.
- `reset` driven low at iteration 15 of a MULT:
  - all outputs go to 0 immediately (asynchronous);
  - no `done` pulse;
  - a fresh DIV 21/7 afterwards completes normally.
